// File: rtl/sumador_rizado_segmentado_if.sv
// Operand/result bundle for the pipelined ripple adder/subtractor.
// The master drives operands, the slave returns results STAGES en=1 cycles later.
// No backpressure: en stalls the whole pipe, valid_out is a one-cycle pulse.
//
// Signals:
//   en        pipeline advance (0 = stall everything)
//   valid_in  a/b/ci/sub carry a new operation this cycle
//   a, b      operands, LSB = bit 0
//   ci        carry in (add mode only)
//   sub       0: a+b+ci, 1: a-b
//   valid_out s/co/ovf carry a completed result
//   s         sum/difference
//   co        carry out of the MSB (sub mode: 1 = no borrow)
//   ovf       signed overflow
interface sumador_rizado_segmentado_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             valid_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             valid_out;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output en, valid_in, a, b, ci, sub,
    input  valid_out, s, co, ovf
  );

  modport slave (
    input  en, valid_in, a, b, ci, sub,
    output valid_out, s, co, ovf
  );
endinterface

// File: rtl/sumador_rizado_segmentado.sv
// Pipelined ripple-carry adder/subtractor, SEG_BITS bits rippled per register stage.
// Latency: STAGES = WIDTH/SEG_BITS en=1 cycles, one operation per en=1 cycle.
// Backpressure: none beyond en; en=0 freezes every stage, valid_in is then dropped.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all valid bits and data registers
//   bus    slave side of sumador_rizado_segmentado_if (operands in, results out)
//
// Each stage k adds bits [k*SEG_BITS +: SEG_BITS]. The operand bits not yet added
// travel forward right-justified (consumed slice shifted out), and finished sum
// slices accumulate below the new slice, so the final stage holds the whole result.
module sumador_rizado_segmentado #(
  parameter int WIDTH    = 16,
  parameter int SEG_BITS = 4,
  parameter int PwrC     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  sumador_rizado_segmentado_if.slave  bus
);

  localparam bit CFG_OK = (SEG_BITS >= 1) &&
                          ((WIDTH % ((SEG_BITS >= 1) ? SEG_BITS : 1)) == 0);
  localparam int STAGES = (SEG_BITS >= 1) ? (WIDTH / SEG_BITS) : 1;

  if (!CFG_OK) begin : g_bad_cfg
    $error("sumador_rizado_segmentado: WIDTH must be a non-zero multiple of SEG_BITS >= 1");
  end

  // Hook for the power-annotation flow; carries no logic.
  if (PwrC != 0) begin : g_pwr_hook
  end

  // Ripple one segment; returns {carry_out, sum}.
  function automatic logic [SEG_BITS:0] ripple(
    input logic [SEG_BITS-1:0] x,
    input logic [SEG_BITS-1:0] y,
    input logic                c0
  );
    logic                c;
    logic [SEG_BITS-1:0] r;
    c = c0;
    r = '0;
    for (int i = 0; i < SEG_BITS; i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, r};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * SEG_BITS;
    localparam int OPW = WIDTH - LO;    // operand bits still to be added

    logic                   in_vld;
    logic                   in_c;
    logic [OPW-1:0]         in_a;
    logic [OPW-1:0]         in_b;
    logic [SEG_BITS:0]      rip;
    logic [LO+SEG_BITS-1:0] nxt_sum;

    logic                   vld_q;
    logic                   cy_q;
    logic [LO+SEG_BITS-1:0] sum_q;

    if (k == 0) begin : g_src
      // Subtraction is a + ~b + 1: invert b once here and force the carry in.
      assign in_vld  = bus.valid_in;
      assign in_c    = bus.sub | bus.ci;
      assign in_a    = bus.a;
      assign in_b    = bus.sub ? ~bus.b : bus.b;
      assign nxt_sum = rip[SEG_BITS-1:0];
    end else begin : g_src
      assign in_vld  = g_stg[k-1].vld_q;
      assign in_c    = g_stg[k-1].cy_q;
      assign in_a    = g_stg[k-1].g_fwd.a_q;
      assign in_b    = g_stg[k-1].g_fwd.b_q;
      assign nxt_sum = {rip[SEG_BITS-1:0], g_stg[k-1].sum_q};
    end

    assign rip = ripple(in_a[SEG_BITS-1:0], in_b[SEG_BITS-1:0], in_c);

    // Valid shifts on every en=1 cycle so bubbles move; data loads only behind
    // a valid, so bubbles leave the data registers untouched.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (bus.en) begin
        vld_q <= in_vld;
        if (in_vld) begin
          cy_q  <= rip[SEG_BITS];
          sum_q <= nxt_sum;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [OPW-SEG_BITS-1:0] a_q;
      logic [OPW-SEG_BITS-1:0] b_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (bus.en && in_vld) begin
          a_q <= in_a[OPW-1:SEG_BITS];
          b_q <= in_b[OPW-1:SEG_BITS];
        end
      end
    end

    if (k == STAGES - 1) begin : g_out
      logic ovf_q;

      // Carry into the MSB is recovered as a^b^s of the top bit, which avoids
      // exporting it from the ripple function.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (bus.en && in_vld) begin
          ovf_q <= rip[SEG_BITS] ^
                   (in_a[SEG_BITS-1] ^ in_b[SEG_BITS-1] ^ rip[SEG_BITS-1]);
        end
      end

      assign bus.valid_out = vld_q;
      assign bus.s         = sum_q;
      assign bus.co        = cy_q;
      assign bus.ovf       = ovf_q;
    end
  end

endmodule

// File: tb/tb_sumador_rizado_segmentado.sv
// Directed self-checking bench for sumador_rizado_segmentado (WIDTH=16, SEG_BITS=4).
// Expected latency is 4 en=1 cycles; all expected values are hand-computed.
// Inputs change 1 ns after the rising edge, outputs are sampled at the same point.
module tb_sumador_rizado_segmentado;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sumador_rizado_segmentado_if #(.WIDTH(16)) bus ();

  sumador_rizado_segmentado #(
    .WIDTH    (16),
    .SEG_BITS (4),
    .PwrC     (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic c, input logic sb);
    bus.valid_in = v;
    bus.a        = x;
    bus.b        = y;
    bus.ci       = c;
    bus.sub      = sb;
  endtask

  // One isolated operation: checks latency, the result, and that valid is a pulse
  // while the result stays put on the following bubble.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic c, input logic sb, input logic [15:0] es,
                        input logic eco, input logic eovf);
    drive(1'b1, x, y, c, sb);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    step();
    check({tag, ".early_vld"}, {31'd0, bus.valid_out}, 32'd0);
    step();
    check({tag, ".vld"}, {31'd0, bus.valid_out}, 32'd1);
    check({tag, ".s"},   {16'd0, bus.s},         {16'd0, es});
    check({tag, ".co"},  {31'd0, bus.co},        {31'd0, eco});
    check({tag, ".ovf"}, {31'd0, bus.ovf},       {31'd0, eovf});
    step();
    check({tag, ".vld_pulse"}, {31'd0, bus.valid_out}, 32'd0);
    check({tag, ".s_hold"},    {16'd0, bus.s},         {16'd0, es});
  endtask

  int          pat [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
  logic [15:0] last_s;
  logic        exp_v;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.en = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst.vld", {31'd0, bus.valid_out}, 32'd0);
    check("rst.s",   {16'd0, bus.s},         32'd0);
    check("rst.co",  {31'd0, bus.co},        32'd0);
    check("rst.ovf", {31'd0, bus.ovf},       32'd0);
    step();
    reset  = 1'b0;
    bus.en = 1'b1;
    step();

    // Carry across segment boundaries, wrap, signed overflow, subtraction
    run_op("add_ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_ci", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back with stalls; junk valid_in during stall must be dropped
    drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0);
    step();
    bus.en = 1'b0;
    drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    check("stall1.vld", {31'd0, bus.valid_out}, 32'd0);
    check("stall1.s",   {16'd0, bus.s},         32'h7FFF);
    step();
    check("stall2.vld", {31'd0, bus.valid_out}, 32'd0);
    check("stall2.s",   {16'd0, bus.s},         32'h7FFF);
    bus.en = 1'b1;
    drive(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0);
    step();
    check("b2b.pre_vld", {31'd0, bus.valid_out}, 32'd0);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    step();
    check("b2b.r0_vld", {31'd0, bus.valid_out}, 32'd1);
    check("b2b.r0_s",   {16'd0, bus.s},         32'h0002);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    bus.en = 1'b0;
    step();
    check("b2b.frz_vld", {31'd0, bus.valid_out}, 32'd1);
    check("b2b.frz_s",   {16'd0, bus.s},         32'h0002);
    bus.en = 1'b1;
    step();
    check("b2b.r1_vld", {31'd0, bus.valid_out}, 32'd1);
    check("b2b.r1_s",   {16'd0, bus.s},         32'h0004);
    step();
    check("b2b.r2_vld", {31'd0, bus.valid_out}, 32'd1);
    check("b2b.r2_s",   {16'd0, bus.s},         32'h0006);
    step();
    check("b2b.r3_vld", {31'd0, bus.valid_out}, 32'd1);
    check("b2b.r3_s",   {16'd0, bus.s},         32'hFFFE);
    check("b2b.r3_co",  {31'd0, bus.co},        32'd1);
    check("b2b.r3_ovf", {31'd0, bus.ovf},       32'd0);
    step();
    check("b2b.end_vld", {31'd0, bus.valid_out}, 32'd0);

    // Bubble pattern: valid_out mirrors valid_in 4 cycles later, s holds in bubbles
    last_s = 16'hFFFE;
    for (int i = 0; i < 12; i++) begin
      if (i < 8)
        drive(pat[i] != 0, 16'(16'h0010 * i), 16'(i), 1'b0, 1'b0);
      else
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      step();
      exp_v = (i >= 3 && i < 11) ? (pat[i-3] != 0) : 1'b0;
      if (exp_v) last_s = 16'(16'h0011 * (i - 3));
      check($sformatf("bub%0d.vld", i), {31'd0, bus.valid_out}, {31'd0, exp_v});
      check($sformatf("bub%0d.s", i),   {16'd0, bus.s},         {16'd0, last_s});
    end

    // Reset mid-stream with two operations in flight
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("pre_rst.s", {16'd0, bus.s}, 32'h0066);
    #2 reset = 1'b1;
    #1;
    check("mid_rst.vld", {31'd0, bus.valid_out}, 32'd0);
    check("mid_rst.s",   {16'd0, bus.s},         32'd0);
    check("mid_rst.co",  {31'd0, bus.co},        32'd0);
    check("mid_rst.ovf", {31'd0, bus.ovf},       32'd0);
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("post_rst%0d.vld", i), {31'd0, bus.valid_out}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
